// File: rtl/ksa_init.sv
// RC4 key-scheduling FSM. It drives a single-port S memory and swaps
// S[i] with S[j] for i = 0..255. Outputs are decoded combinationally
// from the registered state and the i/j/si/sj registers.
// Optional feature macro: KSA_FILL_EN. When it is defined, a FILL phase
// writes S[k] = k before the swaps. When it is undefined, S must already
// hold the identity permutation.
module ksa_init (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_sig,
  input  logic [23:0] secret_key,
  input  logic [7:0]  q_data,
  output logic        finish,
  output logic        ksa_mem_handler,
  output logic [1:0]  memory_sel,
  output logic [7:0]  address,
  output logic [7:0]  data,
  output logic        wen
);

  typedef enum logic [3:0] {
    IDLE, START, FILL,
    RD_I_SETUP, RD_I_WAIT, RD_I_SAMPLE,
    ADD_J,
    RD_J_SETUP, RD_J_WAIT, RD_J_SAMPLE,
    WR_I, WR_J, INC_I, DONE
  } state_t;

  state_t     state;
  logic [7:0] i, j, si, sj;
  logic [7:0] keybyte;
  logic [7:0] i_mod3;

  // The key repeats every three bytes, so i mod 3 selects the key byte.
  assign i_mod3 = i % 8'd3;

  // Select the key byte for the current i.
  always_comb begin
    case (i_mod3)
      8'd0:    keybyte = secret_key[23:16];
      8'd1:    keybyte = secret_key[15:8];
      default: keybyte = secret_key[7:0];
    endcase
  end

  // Sequencer: state transitions and the i/j/si/sj datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
    end else begin
      case (state)
        IDLE:        if (start_sig) state <= START;
        START: begin
          i <= '0;
          j <= '0;
`ifdef KSA_FILL_EN
          state <= FILL;
`else
          state <= RD_I_SETUP;
`endif
        end
`ifdef KSA_FILL_EN
        FILL: begin
          // i wraps from 255 back to 0, which is where the swaps begin.
          i <= i + 8'd1;
          if (i == 8'hFF) state <= RD_I_SETUP;
        end
`endif
        RD_I_SETUP:  state <= RD_I_WAIT;
        RD_I_WAIT:   state <= RD_I_SAMPLE;
        RD_I_SAMPLE: begin
          si    <= q_data;
          state <= ADD_J;
        end
        ADD_J: begin
          j     <= j + si + keybyte;
          state <= RD_J_SETUP;
        end
        RD_J_SETUP:  state <= RD_J_WAIT;
        RD_J_WAIT:   state <= RD_J_SAMPLE;
        RD_J_SAMPLE: begin
          sj    <= q_data;
          state <= WR_I;
        end
        WR_I:        state <= WR_J;
        // When i == j, both writes store the same value, so S is unchanged.
        WR_J:        state <= (i == 8'hFF) ? DONE : INC_I;
        INC_I: begin
          i     <= i + 8'd1;
          state <= RD_I_SETUP;
        end
        DONE:        if (!start_sig) state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

  // Moore output decode of the state and the datapath registers.
  always_comb begin
    finish          = 1'b0;
    ksa_mem_handler = 1'b1;
    memory_sel      = 2'd0;
    address         = 8'd0;
    data            = 8'd0;
    wen             = 1'b0;
    case (state)
      IDLE: ksa_mem_handler = 1'b0;
      DONE: begin
        ksa_mem_handler = 1'b0;
        finish          = 1'b1;
      end
`ifdef KSA_FILL_EN
      FILL: begin
        memory_sel = 2'd1;
        address    = i;
        data       = i;
        wen        = 1'b1;
      end
`endif
      RD_I_SETUP, RD_I_WAIT, RD_I_SAMPLE: begin
        memory_sel = 2'd1;
        address    = i;
      end
      RD_J_SETUP, RD_J_WAIT, RD_J_SAMPLE: begin
        memory_sel = 2'd1;
        address    = j;
      end
      WR_I: begin
        memory_sel = 2'd1;
        address    = i;
        data       = sj;
        wen        = 1'b1;
      end
      WR_J: begin
        memory_sel = 2'd1;
        address    = j;
        data       = si;
        wen        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa_init.sv
// Self-checking bench for ksa_init. It models the S memory with a 2-cycle
// read latency and compares the final S against a software KSA model.
module tb_ksa_init;

`ifdef KSA_FILL_EN
  localparam int FILL_WR = 256;
  localparam int EXP_LAT = 2817;
`else
  localparam int FILL_WR = 0;
  localparam int EXP_LAT = 2561;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_sig = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  q_data;
  logic        finish, ksa_mem_handler, wen;
  logic [1:0]  memory_sel;
  logic [7:0]  address, data;

  ksa_init dut (
    .clk(clk), .reset(reset), .start_sig(start_sig), .secret_key(secret_key),
    .q_data(q_data), .finish(finish), .ksa_mem_handler(ksa_mem_handler),
    .memory_sel(memory_sel), .address(address), .data(data), .wen(wen)
  );

  always #5 clk = ~clk;

  // S memory: 2-cycle registered read, write on the rising edge.
  logic [7:0] mem [256];
  logic [7:0] q1, q2;
  logic       preload_req = 1'b0;
  assign q_data = q2;

  always @(posedge clk) begin
    q1 <= mem[address];
    q2 <= q1;
    if (preload_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wen && memory_sel == 2'd1) begin
      mem[address] <= data;
    end
  end

  // Write monitor plus an illegal memory_sel watcher.
  logic [7:0] wr_addr [8192];
  logic [7:0] wr_data [8192];
  int         wr_cnt = 0;
  int         bad_sel = 0;
  always @(negedge clk) begin
    if (wen) begin
      wr_addr[wr_cnt % 8192] <= address;
      wr_data[wr_cnt % 8192] <= data;
      wr_cnt <= wr_cnt + 1;
    end
    if (memory_sel[1]) bad_sel <= bad_sel + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference KSA over an identity S.
  logic [7:0] model_s [256];
  task automatic compute_model(input logic [23:0] key);
    logic [7:0] jj, t, kb;
    for (int k = 0; k < 256; k++) model_s[k] = 8'(k);
    jj = 0;
    for (int k = 0; k < 256; k++) begin
      case (k % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      jj = jj + model_s[k] + kb;
      t = model_s[k]; model_s[k] = model_s[jj]; model_s[jj] = t;
    end
  endtask

  task automatic preload();
    @(negedge clk); preload_req = 1'b1;
    @(negedge clk); preload_req = 1'b0;
  endtask

  // Start a run from IDLE and return the cycle on which finish is first seen.
  // START is cycle 1 of the run. The bound expiring counts as a failure.
  task automatic run_ksa(input logic [23:0] key, input bit drop_start, output int lat);
    int cyc;
    @(negedge clk);
    secret_key = key;
    start_sig  = 1'b1;
    @(posedge clk);
    cyc = 1;
    forever begin
      @(negedge clk);
      if (finish) break;
      if (cyc > 4000) begin
        check("run_timeout", 32'(cyc), 32'(EXP_LAT));
        break;
      end
      @(posedge clk);
      cyc++;
    end
    lat = cyc;
    if (drop_start) begin
      start_sig = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic check_final_s(input string name, input logic [23:0] key);
    int bad;
    compute_model(key);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== model_s[k]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  // Directed vectors. For an identity S, iteration 0 gives j0 = byte0.
  // The first swap therefore writes addr 0 <- S[j0] = j0 and then addr j0 <- 0.
  typedef struct {
    logic [23:0] key;
    logic [7:0]  wr0_data;
    logic [7:0]  wr1_addr;
    logic [7:0]  wr1_data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int lat, base, bad, seen;
    logic [255:0] hit;

    vecs[0] = '{24'h010203, 8'h01, 8'h01, 8'h00};
    vecs[1] = '{24'h000000, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{24'h4A3B2C, 8'h4A, 8'h4A, 8'h00};

    preload();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {20'd0, finish, ksa_mem_handler, memory_sel, address, wen},
          32'd0);
    check("reset_data", {24'd0, data}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      preload();
      base = wr_cnt;
      run_ksa(vecs[v].key, 1'b1, lat);
      check($sformatf("latency_k%0d", v), 32'(lat), 32'(EXP_LAT));
      check($sformatf("write_count_k%0d", v), 32'(wr_cnt - base), 32'(FILL_WR + 512));
`ifdef KSA_FILL_EN
      bad = 0;
      for (int k = 0; k < 256; k++)
        if (wr_addr[(base + k) % 8192] !== 8'(k) || wr_data[(base + k) % 8192] !== 8'(k)) bad++;
      check($sformatf("fill_trace_k%0d", v), 32'(bad), 32'd0);
`endif
      check($sformatf("swap0_wr_i_addr_k%0d", v), {24'd0, wr_addr[(base + FILL_WR) % 8192]}, 32'd0);
      check($sformatf("swap0_wr_i_data_k%0d", v), {24'd0, wr_data[(base + FILL_WR) % 8192]}, {24'd0, vecs[v].wr0_data});
      check($sformatf("swap0_wr_j_addr_k%0d", v), {24'd0, wr_addr[(base + FILL_WR + 1) % 8192]}, {24'd0, vecs[v].wr1_addr});
      check($sformatf("swap0_wr_j_data_k%0d", v), {24'd0, wr_data[(base + FILL_WR + 1) % 8192]}, {24'd0, vecs[v].wr1_data});
      check_final_s($sformatf("final_s_k%0d", v), vecs[v].key);
      if (vecs[v].key == 24'h000000) begin
        hit = '0;
        for (int k = 0; k < 256; k++) hit[mem[k]] = 1'b1;
        check("perm_k0", {31'd0, &hit}, 32'd1);
      end
      @(negedge clk);
      check($sformatf("idle_after_k%0d", v), {30'd0, finish, ksa_mem_handler}, 32'd0);
    end

    // Reset in the middle of a run, at cycle 1000.
    preload();
    @(negedge clk);
    secret_key = 24'h4A3B2C;
    start_sig  = 1'b1;
    @(posedge clk);
    repeat (999) @(posedge clk);
    @(negedge clk);
    check("midrun_busy", {31'd0, ksa_mem_handler}, 32'd1);
    reset = 1'b1;
    start_sig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset_outputs",
          {12'd0, finish, ksa_mem_handler, memory_sel, address, data, wen},
          32'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset_beats_start", {31'd0, ksa_mem_handler}, 32'd0);
    reset = 1'b0;
    start_sig = 1'b0;
    preload();
    run_ksa(24'h4A3B2C, 1'b1, lat);
    check("post_reset_latency", 32'(lat), 32'(EXP_LAT));
    check_final_s("post_reset_final_s", 24'h4A3B2C);

    // Hold start_sig through DONE, then release it and start a second run.
    preload();
    run_ksa(24'hFFFFFF, 1'b0, lat);
    check("hold_latency", 32'(lat), 32'(EXP_LAT));
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (finish && !ksa_mem_handler && !wen) seen++;
    end
    check("done_hold", 32'(seen), 32'd20);
    start_sig = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("done_to_idle", {30'd0, finish, ksa_mem_handler}, 32'd0);
    preload();
    run_ksa(24'hFFFFFF, 1'b1, lat);
    check("second_run_latency", 32'(lat), 32'(EXP_LAT));
    check_final_s("second_run_final_s", 24'hFFFFFF);

    check("memory_sel_legal", 32'(bad_sel), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
